// File: rtl/rs_dispatch_queue_pkg.sv
// rtl/rs_dispatch_queue_pkg.sv - row type, empty-row constant and port indices for the reservation station
package rs_dispatch_queue_pkg;
   localparam int PREG_W    = 7;
   localparam int XLEN      = 32;
   localparam int ROB_W     = 4;
   localparam int ALUOP_W   = 4;
   localparam int RS_ALU_FU = 2;
   localparam int MEM_PORT  = RS_ALU_FU;
   localparam int FU_W      = $clog2(RS_ALU_FU + 1);

   typedef struct packed {
      logic [PREG_W-1:0]  src0_tag;
      logic [PREG_W-1:0]  src1_tag;
      logic [PREG_W-1:0]  dst_tag;
      logic [PREG_W-1:0]  old_dst_tag;
      logic [XLEN-1:0]    src0_data;
      logic [XLEN-1:0]    src1_data;
      logic [XLEN-1:0]    imm;
      logic [ALUOP_W-1:0] alu_op;
      logic               alu_src;
      logic               reg_write;
      logic               mem_read;
      logic               mem_write;
      logic [ROB_W-1:0]   rob_number;
      logic [FU_W-1:0]    fu;
   } rs_row_struct;

   localparam rs_row_struct RS_ROW_EMPTY = '0;
endpackage

// File: rtl/rs_dispatch_queue_select.sv
// rtl/rs_dispatch_queue_select.sv - picks up to N one-hot grants from an eligibility vector
// RS_AGE_SELECT_EN: oldest-first via the age matrix, otherwise lowest index first.
module rs_select
#(
   parameter int ENTRIES = 16,
   parameter int N       = 1
)
(
   input  logic [ENTRIES-1:0]              elig,
`ifdef RS_AGE_SELECT_EN
   input  logic [ENTRIES-1:0][ENTRIES-1:0] older,
`endif
   output logic [N-1:0][ENTRIES-1:0]       gnt
);
   logic [ENTRIES-1:0] remain;
   logic [ENTRIES-1:0] pick;

   always_comb begin
      remain = elig;
      pick   = '0;
      gnt    = '0;
      for (int n = 0; n < N; n++) begin
`ifdef RS_AGE_SELECT_EN
         // a row wins when it is older than every other remaining row
         for (int i = 0; i < ENTRIES; i++) begin
            pick[i] = remain[i];
            for (int j = 0; j < ENTRIES; j++)
               if (j != i && remain[j] && !older[i][j])
                  pick[i] = 1'b0;
         end
`else
         pick = remain & (~remain + 1'b1);
`endif
         gnt[n] = pick;
         remain = remain & ~pick;
      end
   end
endmodule

// File: rtl/rs_dispatch_queue.sv
// rtl/rs_dispatch_queue.sv - reservation station: dispatch, wakeup capture, ALU/memory issue select
// RS_AGE_SELECT_EN: keep an age matrix and issue oldest-first.
module rs_dispatch_queue
   import rs_dispatch_queue_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int DISP_W  = 2,
   parameter int ALU_FU  = RS_ALU_FU,
   parameter int WAKE_N  = 3
)
(
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic                                i_flush,
   input  logic [DISP_W-1:0]                   i_disp_valid,
   input  rs_row_struct [DISP_W-1:0]           i_disp_row,
   input  logic [2*DISP_W-1:0]                 i_src_ready,
   input  logic [2*DISP_W-1:0][XLEN-1:0]       i_src_data,
   output logic                                o_disp_ready,
   input  logic [WAKE_N-1:0]                   i_wake_valid,
   input  logic [WAKE_N-1:0][PREG_W-1:0]       i_wake_tag,
   input  logic [WAKE_N-1:0][XLEN-1:0]         i_wake_data,
   input  logic [ALU_FU:0]                     i_fu_ready,
   output logic [ALU_FU:0]                     o_issue_valid,
   output rs_row_struct [ALU_FU:0]             o_issue_row,
   output logic [$clog2(ENTRIES+1)-1:0]        o_free_cnt
);
   localparam int CNT_W = $clog2(ENTRIES + 1);

   rs_row_struct [ENTRIES-1:0]        row_q, row_n;
   logic [ENTRIES-1:0]                valid_q, valid_n, rdy0_q, rdy0_n, rdy1_q, rdy1_n;
   logic [ENTRIES-1:0]                free_mask, issue_mask, elig_alu, elig_mem;
   logic [DISP_W-1:0][ENTRIES-1:0]    lane_oh;
   logic [ALU_FU-1:0][ENTRIES-1:0]    gnt_alu;
   logic [0:0][ENTRIES-1:0]           gnt_mem;
   logic [ALU_FU:0][ENTRIES-1:0]      port_oh;
   logic [ALU_FU:0]                   iss_valid;
   rs_row_struct [ALU_FU:0]           iss_row;
   logic [CNT_W-1:0]                  n_written, free_now, free_next;
   logic [XLEN:0]                     w0, w1;
   int                                rank;

   // lowest wake port wins; MSB flags a hit
   function automatic logic [XLEN:0] wake_lookup(input logic [PREG_W-1:0] tag);
      wake_lookup = '0;
      for (int w = WAKE_N - 1; w >= 0; w--)
         if (i_wake_valid[w] && i_wake_tag[w] == tag)
            wake_lookup = {1'b1, i_wake_data[w]};
   endfunction

   always_comb begin
      row_n     = row_q;
      rdy0_n    = rdy0_q;
      rdy1_n    = rdy1_q;
      valid_n   = valid_q & ~issue_mask;
      free_mask = ~valid_q;
      lane_oh   = '0;
      n_written = '0;
      w0        = '0;
      w1        = '0;
      for (int e = 0; e < ENTRIES; e++) begin
         if (valid_q[e] && !rdy0_q[e]) begin
            w0 = wake_lookup(row_q[e].src0_tag);
            if (w0[XLEN]) begin
               rdy0_n[e]           = 1'b1;
               row_n[e].src0_data = w0[XLEN-1:0];
            end
         end
         if (valid_q[e] && !rdy1_q[e]) begin
            w1 = wake_lookup(row_q[e].src1_tag);
            if (w1[XLEN]) begin
               rdy1_n[e]           = 1'b1;
               row_n[e].src1_data = w1[XLEN-1:0];
            end
         end
      end
      // rows freed by this cycle's issue stay out of free_mask until next cycle
      for (int l = 0; l < DISP_W; l++) begin
         if (o_disp_ready && i_disp_valid[l] &&
             (i_disp_row[l].mem_read || i_disp_row[l].mem_write || i_disp_row[l].alu_op != '0)) begin
            lane_oh[l] = free_mask & (~free_mask + 1'b1);
            free_mask  = free_mask & ~lane_oh[l];
            n_written  = n_written + 1'b1;
            w0 = wake_lookup(i_disp_row[l].src0_tag);
            w1 = wake_lookup(i_disp_row[l].src1_tag);
            for (int e = 0; e < ENTRIES; e++) begin
               if (lane_oh[l][e]) begin
                  row_n[e]           = i_disp_row[l];
                  row_n[e].src0_data = w0[XLEN] ? w0[XLEN-1:0] : i_src_data[2*l];
                  row_n[e].src1_data = w1[XLEN] ? w1[XLEN-1:0] : i_src_data[2*l+1];
                  rdy0_n[e]  = i_src_ready[2*l]   || i_disp_row[l].src0_tag == '0 || w0[XLEN];
                  rdy1_n[e]  = i_src_ready[2*l+1] || i_disp_row[l].src1_tag == '0 || w1[XLEN];
                  valid_n[e] = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      free_now = '0;
      for (int e = 0; e < ENTRIES; e++)
         free_now = free_now + CNT_W'(~valid_q[e]);
      free_next = free_now - n_written;
   end

   always_comb begin
      elig_alu = '0;
      elig_mem = '0;
      for (int e = 0; e < ENTRIES; e++) begin
         elig_alu[e] = valid_q[e] && rdy0_q[e] && rdy1_q[e] && !(row_q[e].mem_read || row_q[e].mem_write);
         elig_mem[e] = valid_q[e] && rdy0_q[e] && rdy1_q[e] &&  (row_q[e].mem_read || row_q[e].mem_write);
      end
   end

`ifdef RS_AGE_SELECT_EN
   logic [ENTRIES-1:0][ENTRIES-1:0] older_q, older_n;

   // new rows are younger than residents; earlier lanes are older than later lanes
   always_comb begin
      older_n = older_q;
      for (int l = 0; l < DISP_W; l++)
         for (int e = 0; e < ENTRIES; e++)
            if (lane_oh[l][e])
               for (int j = 0; j < ENTRIES; j++) begin
                  older_n[e][j] = 1'b0;
                  older_n[j][e] = valid_q[j];
                  for (int m = 0; m < DISP_W; m++) begin
                     if (m > l && lane_oh[m][j]) older_n[e][j] = 1'b1;
                     if (m < l && lane_oh[m][j]) older_n[j][e] = 1'b1;
                  end
               end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) older_q <= '0;
      else                  older_q <= older_n;
   end
`endif

   rs_select #(.ENTRIES(ENTRIES), .N(ALU_FU)) u_sel_alu (
      .elig  (elig_alu),
`ifdef RS_AGE_SELECT_EN
      .older (older_q),
`endif
      .gnt   (gnt_alu)
   );

   rs_select #(.ENTRIES(ENTRIES), .N(1)) u_sel_mem (
      .elig  (elig_mem),
`ifdef RS_AGE_SELECT_EN
      .older (older_q),
`endif
      .gnt   (gnt_mem)
   );

   // k-th ready ALU port receives the k-th grant
   always_comb begin
      port_oh    = '0;
      issue_mask = '0;
      rank       = 0;
      for (int p = 0; p < ALU_FU; p++) begin
         if (i_fu_ready[p]) begin
            for (int j = 0; j < ALU_FU; j++)
               if (rank == j) port_oh[p] = gnt_alu[j];
            rank = rank + 1;
         end
      end
      if (i_fu_ready[ALU_FU]) port_oh[ALU_FU] = gnt_mem[0];
      for (int p = 0; p <= ALU_FU; p++)
         issue_mask = issue_mask | port_oh[p];
   end

   always_comb begin
      iss_row   = '0;
      iss_valid = '0;
      for (int p = 0; p <= ALU_FU; p++) begin
         iss_row[p] = RS_ROW_EMPTY;
         for (int e = 0; e < ENTRIES; e++)
            if (port_oh[p][e]) iss_row[p] = row_q[e];
         iss_valid[p] = |port_oh[p];
         if (iss_valid[p]) iss_row[p].fu = FU_W'(p);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         row_q         <= '0;
         valid_q       <= '0;
         rdy0_q        <= '0;
         rdy1_q        <= '0;
         o_issue_valid <= '0;
         o_issue_row   <= '0;
         o_free_cnt    <= CNT_W'(ENTRIES);
         o_disp_ready  <= 1'b1;
      end else begin
         row_q         <= row_n;
         valid_q       <= valid_n;
         rdy0_q        <= rdy0_n;
         rdy1_q        <= rdy1_n;
         o_issue_valid <= iss_valid;
         o_issue_row   <= iss_row;
         o_free_cnt    <= free_next;
         o_disp_ready  <= free_next >= CNT_W'(DISP_W);
      end
   end
endmodule

// File: tb/tb_rs_dispatch_queue.sv
// tb/tb_rs_dispatch_queue.sv - self-checking bench for rs_dispatch_queue (default select build)
module tb_rs_dispatch_queue;
   import rs_dispatch_queue_pkg::*;

   logic                        i_clk = 1'b0;
   logic                        i_rst, i_flush;
   logic [1:0]                  i_disp_valid;
   rs_row_struct [1:0]          i_disp_row;
   logic [3:0]                  i_src_ready;
   logic [3:0][31:0]            i_src_data;
   logic                        o_disp_ready;
   logic [2:0]                  i_wake_valid;
   logic [2:0][6:0]             i_wake_tag;
   logic [2:0][31:0]            i_wake_data;
   logic [2:0]                  i_fu_ready;
   logic [2:0]                  o_issue_valid;
   rs_row_struct [2:0]          o_issue_row;
   logic [4:0]                  o_free_cnt;

   rs_dispatch_queue dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
      .i_disp_valid(i_disp_valid), .i_disp_row(i_disp_row),
      .i_src_ready(i_src_ready), .i_src_data(i_src_data), .o_disp_ready(o_disp_ready),
      .i_wake_valid(i_wake_valid), .i_wake_tag(i_wake_tag), .i_wake_data(i_wake_data),
      .i_fu_ready(i_fu_ready), .o_issue_valid(o_issue_valid), .o_issue_row(o_issue_row),
      .o_free_cnt(o_free_cnt)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int          port;
      logic [31:0] s0;
      logic [31:0] s1;
      logic [3:0]  rob;
   } exp_t;

   typedef struct {
      logic [3:0] alu_op;
      logic       mr;
      logic       mw;
      logic [2:0] fu_ready;
      int         port;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[6];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      for (int p = 0; p < 3; p++) begin
         if (o_issue_valid[p]) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue port=%0d rob=%0h", p, o_issue_row[p].rob_number);
            end else begin
               e = sb.pop_front();
               check("issue_port", p, e.port);
               check("issue_fu", o_issue_row[p].fu, p);
               check("issue_src0", o_issue_row[p].src0_data, e.s0);
               check("issue_src1", o_issue_row[p].src1_data, e.s1);
               check("issue_rob", o_issue_row[p].rob_number, e.rob);
            end
         end else begin
            check("idle_row_zero", |o_issue_row[p], 0);
         end
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      @(negedge i_clk);
      monitor();
   endtask

   task automatic clear_inputs();
      i_disp_valid = '0;
      i_disp_row   = '0;
      i_src_ready  = '0;
      i_src_data   = '0;
      i_wake_valid = '0;
      i_wake_tag   = '0;
      i_wake_data  = '0;
   endtask

   task automatic set_lane(input int l, input logic [3:0] op, input logic mr, input logic mw,
                           input logic [6:0] t0, input logic [6:0] t1, input logic r0, input logic r1,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [3:0] rob);
      i_disp_valid[l]          = 1'b1;
      i_disp_row[l]            = '0;
      i_disp_row[l].alu_op     = op;
      i_disp_row[l].mem_read   = mr;
      i_disp_row[l].mem_write  = mw;
      i_disp_row[l].src0_tag   = t0;
      i_disp_row[l].src1_tag   = t1;
      i_disp_row[l].rob_number = rob;
      i_disp_row[l].reg_write  = 1'b1;
      i_src_ready[2*l]         = r0;
      i_src_ready[2*l+1]       = r1;
      i_src_data[2*l]          = d0;
      i_src_data[2*l+1]        = d1;
   endtask

   task automatic push(input int port, input logic [31:0] s0, input logic [31:0] s1, input logic [3:0] rob);
      exp_t e;
      e.port = port; e.s0 = s0; e.s1 = s1; e.rob = rob;
      sb.push_back(e);
   endtask

   initial begin
      vecs[0] = '{alu_op: 4'd1, mr: 1'b0, mw: 1'b0, fu_ready: 3'b111, port:  0};
      vecs[1] = '{alu_op: 4'd3, mr: 1'b0, mw: 1'b0, fu_ready: 3'b110, port:  1};
      vecs[2] = '{alu_op: 4'd0, mr: 1'b1, mw: 1'b0, fu_ready: 3'b111, port:  2};
      vecs[3] = '{alu_op: 4'd5, mr: 1'b0, mw: 1'b1, fu_ready: 3'b111, port:  2};
      vecs[4] = '{alu_op: 4'd0, mr: 1'b0, mw: 1'b0, fu_ready: 3'b111, port: -1};
      vecs[5] = '{alu_op: 4'd2, mr: 1'b0, mw: 1'b0, fu_ready: 3'b101, port:  0};

      clear_inputs();
      i_flush = 1'b0; i_fu_ready = 3'b111; i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check("reset_free", o_free_cnt, 16);
      check("reset_ready", o_disp_ready, 1);
      check("reset_valid", o_issue_valid, 0);

      // two adds, sources ready
      set_lane(0, 4'd1, 0, 0, 7'd1, 7'd2, 1, 1, 32'h10, 32'h11, 4'd1);
      set_lane(1, 4'd1, 0, 0, 7'd3, 7'd4, 1, 1, 32'h20, 32'h21, 4'd2);
      push(0, 32'h10, 32'h11, 4'd1);
      push(1, 32'h20, 32'h21, 4'd2);
      tick();
      clear_inputs();
      check("add_write_valid", o_issue_valid, 0);
      check("add_write_free", o_free_cnt, 14);
      tick();
      check("add_issue_valid", o_issue_valid, 3'b011);
      tick();
      check("add_free_back", o_free_cnt, 16);
      check("add_sb_empty", sb.size(), 0);

      // wakeup after dispatch, lowest wake port wins
      set_lane(0, 4'd4, 0, 0, 7'd9, 7'd0, 0, 0, 32'h1111, 32'h2222, 4'd3);
      push(0, 32'hDEADBEEF, 32'h2222, 4'd3);
      tick();
      clear_inputs();
      tick();
      tick();
      check("wait_no_issue", o_issue_valid, 0);
      i_wake_valid = 3'b110;
      i_wake_tag[1] = 7'd9; i_wake_data[1] = 32'hDEADBEEF;
      i_wake_tag[2] = 7'd9; i_wake_data[2] = 32'h12345678;
      tick();
      clear_inputs();
      check("wake_edge1", o_issue_valid, 0);
      tick();
      check("wake_edge2", o_issue_valid, 3'b001);
      check("wake_sb_empty", sb.size(), 0);

      // wakeup in the dispatch cycle
      set_lane(0, 4'd1, 0, 0, 7'd3, 7'd5, 1, 0, 32'hAAAA, 32'hBBBB, 4'd4);
      i_wake_valid[0] = 1'b1; i_wake_tag[0] = 7'd5; i_wake_data[0] = 32'hCAFEF00D;
      push(0, 32'hAAAA, 32'hCAFEF00D, 4'd4);
      tick();
      clear_inputs();
      tick();
      check("same_cycle_wake", o_issue_valid, 3'b001);

      // classification table
      for (int v = 0; v < 6; v++) begin
         i_fu_ready = vecs[v].fu_ready;
         set_lane(0, vecs[v].alu_op, vecs[v].mr, vecs[v].mw, 7'd7, 7'd8, 1, 1,
                  32'h100 + v, 32'h200 + v, 4'(v + 8));
         if (vecs[v].port >= 0) push(vecs[v].port, 32'h100 + v, 32'h200 + v, 4'(v + 8));
         tick();
         clear_inputs();
         tick();
         check($sformatf("vec%0d_issue", v), o_issue_valid,
               (vecs[v].port >= 0) ? (64'd1 << vecs[v].port) : 64'd0);
         tick();
         check($sformatf("vec%0d_free", v), o_free_cnt, 16);
         check($sformatf("vec%0d_sb", v), sb.size(), 0);
      end

      // fill to 15 rows with all ports stalled
      i_fu_ready = 3'b000;
      for (int c = 0; c < 7; c++) begin
         set_lane(0, 4'd1, 0, 0, 7'd1, 7'd1, 1, 1, 32'(2*c), 32'(2*c + 100), 4'(2*c));
         set_lane(1, 4'd1, 0, 0, 7'd1, 7'd1, 1, 1, 32'(2*c + 1), 32'(2*c + 101), 4'(2*c + 1));
         tick();
      end
      clear_inputs();
      check("fill14_free", o_free_cnt, 2);
      check("fill14_ready", o_disp_ready, 1);
      set_lane(0, 4'd1, 0, 0, 7'd1, 7'd1, 1, 1, 32'd14, 32'd114, 4'd14);
      tick();
      check("fill15_free", o_free_cnt, 1);
      check("fill15_ready", o_disp_ready, 0);
      set_lane(1, 4'd1, 0, 0, 7'd1, 7'd1, 1, 1, 32'd15, 32'd115, 4'd15);
      tick();
      clear_inputs();
      check("full_drop_free", o_free_cnt, 1);
      push(0, 32'd0, 32'd100, 4'd0);
      i_fu_ready = 3'b001;
      tick();
      i_fu_ready = 3'b000;
      check("full_issue_one", o_issue_valid, 3'b001);
      check("full_ready_lag", o_disp_ready, 0);
      tick();
      check("full_ready_back", o_disp_ready, 1);
      check("full_free_two", o_free_cnt, 2);

      // flush with dispatch, wakeup and ready ports all active
      set_lane(0, 4'd1, 0, 0, 7'd1, 7'd1, 1, 1, 32'd1, 32'd2, 4'd1);
      i_wake_valid = 3'b001; i_wake_tag[0] = 7'd1;
      i_fu_ready = 3'b111;
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      clear_inputs();
      check("flush_free", o_free_cnt, 16);
      check("flush_valid", o_issue_valid, 0);
      check("flush_ready", o_disp_ready, 1);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("post_flush_idle", o_issue_valid, 0);
      end

      // load and store with the memory port toggling
      i_fu_ready = 3'b011;
      set_lane(0, 4'd0, 1, 0, 7'd2, 7'd0, 1, 0, 32'h500, 32'h0, 4'd5);
      set_lane(1, 4'd0, 0, 1, 7'd2, 7'd3, 1, 1, 32'h600, 32'h601, 4'd6);
      push(2, 32'h500, 32'h0, 4'd5);
      push(2, 32'h600, 32'h601, 4'd6);
      tick();
      clear_inputs();
      tick();
      check("mem_stalled", o_issue_valid, 0);
      i_fu_ready = 3'b111;
      tick();
      check("mem_load", o_issue_valid, 3'b100);
      i_fu_ready = 3'b011;
      tick();
      check("mem_stalled2", o_issue_valid, 0);
      i_fu_ready = 3'b111;
      tick();
      check("mem_store", o_issue_valid, 3'b100);
      tick();
      check("mem_done", o_issue_valid, 0);
      check("mem_sb_empty", sb.size(), 0);

      // reset in the cycle a row would issue
      set_lane(0, 4'd1, 0, 0, 7'd1, 7'd1, 1, 1, 32'd7, 32'd8, 4'd7);
      tick();
      clear_inputs();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check("rst_mid_valid", o_issue_valid, 0);
      check("rst_mid_free", o_free_cnt, 16);
      tick();
      check("rst_mid_after", o_issue_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
